pipelined_mac_array: RTL and testbench
======================================

PIPELINED_MAC_ARRAY -- requirements
Module: pipelined_mac_array

Interface
REQ-001 Parameter XLEN, default 5: width of every operand, weight and result, in the codebase floating-point format.
REQ-002 Parameter LANES, default 8: number of parallel multiply lanes; SHALL be a power of two, at least 2.
REQ-003 Parameter CNTW, default 8: width of the beat counter.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  beat present on nums/weights.
REQ-007 in_ready  output  1  beat accepted on the edge where in_valid & in_ready.
REQ-008 in_last  input  1  accepted beat closes the current packet.
REQ-009 nums  input  LANES*XLEN  operands; lane i occupies bits [i*XLEN +: XLEN].
REQ-010 weights  input  LANES*XLEN  weights, same packing as nums.
REQ-011 relu_en  input  1  sampled with each last beat; clamps a negative packet result to zero.
REQ-012 out_valid  output  1  result and beats are valid.
REQ-013 out_ready  input  1  consumer accepts the result on the edge where out_valid & out_ready.
REQ-014 result  output  XLEN  accumulated packet sum.
REQ-015 beats  output  CNTW  number of beats in the reported packet.

Function
REQ-016 Multiply and add SHALL reuse the FloatingMultiplication and FloatingAddition modules, instantiated with XLEN; there SHALL be no other arithmetic.
REQ-017 Stage M registers the LANES products of an accepted beat; the beat's valid and last flags travel with it.
REQ-018 The adder tree has log2(LANES) levels, each registered; level k pairs adjacent entries 2j and 2j+1.
REQ-019 Stage A accumulates each tree output.
  - Within a packet, the first beat loads acc = tree sum.
  - Later beats load acc = acc + tree sum, adding acc on input a.
REQ-020 On a last beat, stage A loads result with the final sum.
  - If relu_en (carried from that beat) is set and the sum's MSB is 1, result is loaded as all-zeros.
  - beats is loaded with the packet's beat count.
  - out_valid is set; the accumulator re-arms for the first-beat case.
REQ-021 The beat counter increments on each accumulated beat and restarts at 1 on a first beat.
  - It saturates at 2^CNTW-1; it never wraps.
REQ-022 Stall: advance = ~out_valid | out_ready; in_ready = advance.
  - All pipeline registers, including flags, hold when advance is 0.
REQ-023 out_valid clears on the handshake edge unless a new last beat completes on that same edge; in that case it stays 1 and result/beats update.
REQ-024 Latency: a single-beat packet accepted at edge t SHALL show out_valid=1 after edge t+log2(LANES)+2 with no stall; each stalled cycle adds one.
REQ-025 Throughput SHALL be one beat per cycle with no bubbles when out_ready=1.
REQ-026 Beats with in_valid=0 SHALL leave acc, the counter and all outputs unchanged.
REQ-027 in_last on every beat SHALL produce one result per beat, each independent of the previous one.

Reset
REQ-028 When rst is asserted, asynchronously and at any time including mid-packet or during a stall:
  - out_valid=0, result=0, beats=0, acc=0;
  - all stage valid flags 0;
  - the accumulator is armed for the first-beat case.
REQ-029 in_ready SHALL be 1 while and after rst is asserted.
REQ-030 A partial packet in flight at reset SHALL be discarded; it never appears on result.

Verification
REQ-031 LANES=4, one beat, all nums=1.0 and weights=1.0, last=1, out_ready=1 -> after 4 edges: out_valid=1, result=4.0, beats=1.
REQ-032 Three back-to-back beats of all 1.0 * 1.0, last on the third -> one result: 12.0, beats=3, out_valid high exactly 1 cycle.
REQ-033 One beat of all -1.0 * 1.0, relu_en=1 -> result=0; same beat with relu_en=0 -> result=-4.0.
REQ-034 out_ready=0 with two last-beat packets pending -> in_ready drops, first result is held stable, no loss; raising out_ready delivers both results in order.
REQ-035 Assert rst after 2 of 3 beats, then send a 1-beat packet -> the only result is that packet's, with beats=1.
REQ-036 CNTW=2, a 5-beat packet -> beats=3 (saturated), and result is still the correct 5-beat sum.

Source files
------------

// File: rtl/pipelined_mac_array.sv
// Pipelined dot-product MAC: LANES parallel float multiplies, a registered adder tree,
// and a per-packet accumulator with optional ReLU clamp, all behind one valid/ready stall.

// Float format: sign, EW exponent bits (bias 2^(EW-1)-1), MW mantissa bits.
// A zero exponent field means zero; results truncate, saturate on overflow, flush on underflow.
module FloatingMultiplication #(
  parameter int XLEN = 5
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);
  localparam int EW = (XLEN + 1) / 2;
  localparam int MW = XLEN - 1 - EW;
  localparam logic signed [EW+1:0] E_BIAS = (EW+2)'((1 << (EW - 1)) - 1);
  localparam logic signed [EW+1:0] E_MAX  = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] E_ONE  = (EW+2)'(1);
  localparam logic signed [EW+1:0] E_ZERO = '0;

  logic [2*MW+1:0]       w_p;
  logic signed [EW+1:0]  w_e;
  logic [MW-1:0]         w_m;
  logic                  w_s;

  always_comb begin
    w_s = i_a[XLEN-1] ^ i_b[XLEN-1];
    w_p = (2*MW+2)'({1'b1, i_a[MW-1:0]}) * (2*MW+2)'({1'b1, i_b[MW-1:0]});
    w_e = $signed({2'b00, i_a[XLEN-2 -: EW]}) + $signed({2'b00, i_b[XLEN-2 -: EW]}) - E_BIAS
          + (w_p[2*MW+1] ? E_ONE : E_ZERO);
    w_m = w_p[2*MW+1] ? w_p[2*MW -: MW] : w_p[2*MW-1 -: MW];
    o_y = '0;
    if (i_a[XLEN-2 -: EW] != '0 && i_b[XLEN-2 -: EW] != '0) begin
      if (w_e > E_MAX)       o_y = {w_s, {EW{1'b1}}, {MW{1'b1}}};
      else if (w_e > E_ZERO) o_y = {w_s, w_e[EW-1:0], w_m};
    end
  end
endmodule

module FloatingAddition #(
  parameter int XLEN = 5
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);
  localparam int EW = (XLEN + 1) / 2;
  localparam int MW = XLEN - 1 - EW;
  localparam int G  = 3;
  localparam int SW = MW + 1 + G;
  localparam logic signed [EW+1:0] E_MAX  = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] E_ONE  = (EW+2)'(1);
  localparam logic signed [EW+1:0] E_ZERO = '0;

  logic [XLEN-1:0]      w_big, w_sml;
  logic [EW-1:0]        w_d;
  logic [SW:0]          w_bs, w_ss, w_s;
  logic signed [EW+1:0] w_e;

  always_comb begin
    if (i_a[XLEN-2:0] >= i_b[XLEN-2:0]) begin
      w_big = i_a;
      w_sml = i_b;
    end else begin
      w_big = i_b;
      w_sml = i_a;
    end
    w_d  = w_big[XLEN-2 -: EW] - w_sml[XLEN-2 -: EW];
    w_bs = {2'b01, w_big[MW-1:0], {G{1'b0}}};
    w_ss = {2'b01, w_sml[MW-1:0], {G{1'b0}}} >> w_d;
    w_e  = $signed({2'b00, w_big[XLEN-2 -: EW]});
    w_s  = '0;
    o_y  = '0;
    if (w_sml[XLEN-2 -: EW] == '0) begin
      o_y = (w_big[XLEN-2 -: EW] == '0) ? '0 : w_big;
    end else begin
      w_s = (w_big[XLEN-1] == w_sml[XLEN-1]) ? w_bs + w_ss : w_bs - w_ss;
      if (w_s[SW]) begin
        w_s = w_s >> 1;
        w_e = w_e + E_ONE;
      end
      // Cancellation in a subtraction can leave the leading one far down.
      for (int i = 0; i < SW; i++) begin
        if (w_s != '0 && !w_s[SW-1]) begin
          w_s = w_s << 1;
          w_e = w_e - E_ONE;
        end
      end
      if (w_s == '0)         o_y = '0;
      else if (w_e > E_MAX)  o_y = {w_big[XLEN-1], {EW{1'b1}}, {MW{1'b1}}};
      else if (w_e > E_ZERO) o_y = {w_big[XLEN-1], w_e[EW-1:0], w_s[SW-2 -: MW]};
    end
  end
endmodule

module pipelined_mac_array #(
  parameter int XLEN  = 5,
  parameter int LANES = 8,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*XLEN-1:0] nums,
  input  logic [LANES*XLEN-1:0] weights,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic [CNTW-1:0]       beats
);
  localparam int LVL = $clog2(LANES);
  // Flag pipe: [0] operand regs, [1] products, [2..LVL+1] adder tree levels.
  localparam int NS  = LVL + 2;

  logic                  w_adv;
  logic [LANES*XLEN-1:0] r_nums, r_wts;
  logic [XLEN-1:0]       w_prod [LANES];
  logic [XLEN-1:0]       w_sum  [1:LANES-1];
  logic [XLEN-1:0]       r_node [1:2*LANES-1];
  logic [NS-1:0]         r_v, r_l, r_r;
  logic [XLEN-1:0]       r_acc, w_acc_sum, w_total;
  logic                  r_first, w_done;
  logic [CNTW-1:0]       r_cnt, w_cnt;
  logic                  r_out_valid;
  logic [XLEN-1:0]       r_result;
  logic [CNTW-1:0]       r_beats;

  assign w_adv     = ~r_out_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign beats     = r_beats;

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    FloatingMultiplication #(.XLEN(XLEN)) u_mul (
      .i_a(r_nums[i*XLEN +: XLEN]),
      .i_b(r_wts[i*XLEN +: XLEN]),
      .o_y(w_prod[i])
    );
  end

  // Heap layout: products sit in nodes LANES..2*LANES-1, node n sums 2n and 2n+1, root is node 1.
  for (genvar n = 1; n < LANES; n++) begin : g_add
    FloatingAddition #(.XLEN(XLEN)) u_add (
      .i_a(r_node[2*n]),
      .i_b(r_node[2*n+1]),
      .o_y(w_sum[n])
    );
  end

  FloatingAddition #(.XLEN(XLEN)) u_acc (
    .i_a(r_acc),
    .i_b(r_node[1]),
    .o_y(w_acc_sum)
  );

  always_comb begin
    w_total = r_first ? r_node[1] : w_acc_sum;
    w_cnt   = r_first ? CNTW'(1) : ((&r_cnt) ? r_cnt : r_cnt + CNTW'(1));
    w_done  = r_v[NS-1] & r_l[NS-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nums <= '0;
      r_wts  <= '0;
      r_v    <= '0;
      r_l    <= '0;
      r_r    <= '0;
      for (int n = 1; n < 2*LANES; n++) r_node[n] <= '0;
    end else if (w_adv) begin
      r_nums <= nums;
      r_wts  <= weights;
      r_v    <= {r_v[NS-2:0], in_valid};
      r_l    <= {r_l[NS-2:0], in_last};
      r_r    <= {r_r[NS-2:0], relu_en};
      for (int i = 0; i < LANES; i++) r_node[LANES+i] <= w_prod[i];
      for (int n = 1; n < LANES; n++)  r_node[n] <= w_sum[n];
    end
  end

  // While advancing, a held result has just been taken, so out_valid follows w_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_first     <= 1'b1;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_beats     <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_done;
      if (r_v[NS-1]) begin
        r_acc   <= w_total;
        r_cnt   <= w_cnt;
        r_first <= r_l[NS-1];
      end
      if (w_done) begin
        r_result <= (r_r[NS-1] && w_total[XLEN-1]) ? '0 : w_total;
        r_beats  <= w_cnt;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_mac_array.sv
// Bench for pipelined_mac_array (XLEN=5, LANES=4, CNTW=2): directed cases plus random
// packets under random backpressure, checked against an expected-result queue.
module tb_pipelined_mac_array;
  localparam int XLEN  = 5;
  localparam int LANES = 4;
  localparam int CNTW  = 2;
  localparam int DW    = LANES * XLEN;
  localparam int W     = CNTW + XLEN;

  // Encodings: sign, 3-bit exponent (bias 3), 1 mantissa bit.
  localparam logic [XLEN-1:0] F_ZERO  = 5'b00000;
  localparam logic [XLEN-1:0] F_ONE   = 5'b00110;
  localparam logic [XLEN-1:0] F_MONE  = 5'b10110;
  localparam logic [XLEN-1:0] F_TWO   = 5'b01000;
  localparam logic [XLEN-1:0] F_FOUR  = 5'b01010;
  localparam logic [XLEN-1:0] F_MFOUR = 5'b11010;
  localparam logic [XLEN-1:0] F_EIGHT = 5'b01100;
  localparam logic [XLEN-1:0] F_M8    = 5'b11100;
  localparam logic [XLEN-1:0] F_12    = 5'b01101;
  localparam logic [XLEN-1:0] F_M12   = 5'b11101;
  localparam logic [XLEN-1:0] F_16    = 5'b01110;
  localparam logic [XLEN-1:0] F_M16   = 5'b11110;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_last, relu_en;
  logic [DW-1:0]   nums, weights;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] result;
  logic [CNTW-1:0] beats;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_bad    = 0;
  int rdy_mode = 0;

  pipelined_mac_array #(.XLEN(XLEN), .LANES(LANES), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .nums(nums), .weights(weights), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .beats(beats)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [XLEN-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [DW-1:0] lane0(input logic [XLEN-1:0] v);
    return {{((LANES-1)*XLEN){1'b0}}, v};
  endfunction

  // Packet of n beats, every lane +-1.0 * 1.0, so each beat contributes +-4.0.
  function automatic logic [W-1:0] exp_uniform(input int n, input bit neg, input bit relu);
    logic [XLEN-1:0] v;
    logic [CNTW-1:0] b;
    case (n)
      1:       v = neg ? F_MFOUR : F_FOUR;
      2:       v = neg ? F_M8    : F_EIGHT;
      3:       v = neg ? F_M12   : F_12;
      default: v = neg ? F_M16   : F_16;
    endcase
    if (neg && relu) v = F_ZERO;
    b = (n > 3) ? CNTW'(3) : CNTW'(n);
    return {b, v};
  endfunction

  // driver tasks
  task automatic send_beat(input logic [DW-1:0] n, input logic [DW-1:0] w,
                           input logic last, input logic relu, input int gap);
    int tries;
    tries = 0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      nums     = DW'($urandom);
      weights  = DW'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      relu_en  = 1'($urandom_range(0, 1));
    end
    forever begin
      @(negedge clk);
      in_valid = 1'b1;
      nums     = n;
      weights  = w;
      in_last  = last;
      relu_en  = relu;
      #4;
      if (in_ready) begin
        @(posedge clk);
        return;
      end
      tries++;
      if (tries > 300) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_packet(input int n, input bit neg, input bit relu, input int gap_max);
    exp_q.push_back(exp_uniform(n, neg, relu));
    for (int b = 0; b < n; b++)
      send_beat(fill(neg ? F_MONE : F_ONE), fill(F_ONE), b == n - 1,
                (b == n - 1) ? relu : !relu, $urandom_range(0, gap_max));
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 400 && (exp_q.size() != 0 || out_valid); c++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  // scoreboard: compare on each handshake, and hold-stability while stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #4;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0)  check("extra_output", 1, 0);
        else if (out_ready)     check("out", {beats, result}, exp_q.pop_front());
        else                    check("hold", {beats, result}, exp_q[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; relu_en = 1'b0;
    nums = '0; weights = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_beats", beats, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single beat: latency and 4 x 1.0 = 4.0
    exp_q.push_back({CNTW'(1), F_FOUR});
    send_beat(fill(F_ONE), fill(F_ONE), 1'b1, 1'b0, 0);
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_edge%0d", k), out_valid, (k == 4) ? 1 : 0);
    end
    wait_drain();

    // three back-to-back beats -> 12.0, beats=3
    send_packet(3, 1'b0, 1'b0, 0);
    idle();
    wait_drain();

    // negative beat with and without ReLU
    send_packet(1, 1'b1, 1'b1, 0);
    send_packet(1, 1'b1, 1'b0, 0);
    idle();
    wait_drain();

    // backpressure with two results pending
    rdy_mode = 1;
    send_packet(1, 1'b0, 1'b0, 0);
    send_packet(1, 1'b1, 1'b0, 0);
    idle();
    repeat (8) @(negedge clk);
    #4;
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    rdy_mode = 0;
    wait_drain();

    // five beats with saturating counter: 1+1+2+4+8 = 16.0, beats=3
    exp_q.push_back({CNTW'(3), F_16});
    send_beat(lane0(F_ONE),   fill(F_ONE), 1'b0, 1'b0, 0);
    send_beat(lane0(F_ONE),   fill(F_ONE), 1'b0, 1'b0, 0);
    send_beat(lane0(F_TWO),   fill(F_ONE), 1'b0, 1'b0, 0);
    send_beat(lane0(F_FOUR),  fill(F_ONE), 1'b0, 1'b0, 0);
    send_beat(lane0(F_EIGHT), fill(F_ONE), 1'b1, 1'b0, 0);
    idle();
    wait_drain();

    // reset mid-packet: partial packet discarded
    send_beat(fill(F_ONE), fill(F_ONE), 1'b0, 1'b0, 0);
    send_beat(fill(F_ONE), fill(F_ONE), 1'b0, 1'b0, 0);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_beats", beats, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_packet(1, 1'b0, 1'b0, 0);
    idle();
    wait_drain();

    // random packets, gaps and backpressure
    rdy_mode = 2;
    for (int p = 0; p < 24; p++)
      send_packet($urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
    idle();
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
